// File: rtl/dmem_if.sv
// Request/response bundle between the core's memory port (master) and the data-memory responder (slave).
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable access latency and a stall line for the core.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned / out-of-range accesses via rsp_err instead of wrapping.
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int DATA_W = 32;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_we_p0;
  logic                r_err_p0;
  logic [IDX_W-1:0]    r_idx_p0;
  logic [DATA_W-1:0]   r_wdata_p0;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_accept;
  logic                w_enter_resp;
  logic                w_in_err;
  logic [IDX_W-1:0]    w_in_idx;
  logic                w_acc_we;
  logic                w_acc_err;
  logic [IDX_W-1:0]    w_acc_idx;
  logic [DATA_W-1:0]   w_acc_wdata;
  logic                w_mem_wr;

  assign w_in_idx = bus.req_addr[IDX_W+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_in_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr >= 32'(DEPTH * 4));
`else
  logic w_unused_addr;
  assign w_in_err      = 1'b0;
  assign w_unused_addr = ^{bus.req_addr[31:IDX_W+2], bus.req_addr[1:0]};
`endif

  assign w_accept     = (r_state == S_IDLE) && bus.req_valid;
  assign w_enter_resp = (LATENCY == 1) ? w_accept
                                       : ((r_state == S_WAIT) && (r_cnt == CNT_W'(1)));

  // With LATENCY==1 the array is accessed on the accept edge, so take the live request.
  assign w_acc_we    = (LATENCY == 1) ? bus.req_we    : r_we_p0;
  assign w_acc_err   = (LATENCY == 1) ? w_in_err      : r_err_p0;
  assign w_acc_idx   = (LATENCY == 1) ? w_in_idx      : r_idx_p0;
  assign w_acc_wdata = (LATENCY == 1) ? bus.req_wdata : r_wdata_p0;
  assign w_mem_wr    = w_enter_resp && w_acc_we && !w_acc_err && !rst;

  // p0: request captured at acceptance
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we_p0    <= bus.req_we;
      r_err_p0   <= w_in_err;
      r_idx_p0   <= w_in_idx;
      r_wdata_p0 <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_wr) r_mem[w_acc_idx] <= w_acc_wdata;
  end

  // p1: control FSM and response registers, loaded on the edge entering RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_cnt   <= CNT_LOAD;
            r_state <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_enter_resp) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_acc_err;
        r_rsp_rdata <= (w_acc_we || w_acc_err) ? '0 : r_mem[w_acc_idx];
      end
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state == S_WAIT) || ((r_state == S_IDLE) && bus.req_valid);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 3) checked every cycle against a timeline model.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_if bus0 ();
  dmem_if bus1 ();
  dmem_if bus2 ();

  dmem_responder #(.DEPTH(64), .LATENCY(2)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  dmem_responder #(.DEPTH(64), .LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  dmem_responder #(.DEPTH(64), .LATENCY(3)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic [2:0]  v_valid = '0;
  logic [2:0]  v_we    = '0;
  logic [31:0] v_addr  [3];
  logic [31:0] v_wdata [3];

  logic [2:0]  o_ready, o_busy, o_rvalid, o_err;
  logic [31:0] o_rdata [3];

  assign bus0.req_valid = v_valid[0];
  assign bus0.req_we    = v_we[0];
  assign bus0.req_addr  = v_addr[0];
  assign bus0.req_wdata = v_wdata[0];
  assign bus1.req_valid = v_valid[1];
  assign bus1.req_we    = v_we[1];
  assign bus1.req_addr  = v_addr[1];
  assign bus1.req_wdata = v_wdata[1];
  assign bus2.req_valid = v_valid[2];
  assign bus2.req_we    = v_we[2];
  assign bus2.req_addr  = v_addr[2];
  assign bus2.req_wdata = v_wdata[2];

  assign o_ready  = {bus2.req_ready, bus1.req_ready, bus0.req_ready};
  assign o_busy   = {bus2.busy, bus1.busy, bus0.busy};
  assign o_rvalid = {bus2.rsp_valid, bus1.rsp_valid, bus0.rsp_valid};
  assign o_err    = {bus2.rsp_err, bus1.rsp_err, bus0.rsp_err};
  assign o_rdata[0] = bus0.rsp_rdata;
  assign o_rdata[1] = bus1.rsp_rdata;
  assign o_rdata[2] = bus2.rsp_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic int lat(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 3;
  endfunction

  function automatic logic [5:0] idx_of(input logic [31:0] a);
    return a[7:2];
  endfunction

  function automatic logic err_of(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    return (a[1:0] != 2'b00) || (a >= 32'd256);
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: each instance is a timeline of accept / response / next-free cycles.
  int          cyc = 0;
  bit          model_ok = 0;
  int          t_acc [3];
  int          t_rsp [3];
  int          t_free[3];
  logic        p_we  [3];
  logic        p_err [3];
  logic [5:0]  p_idx [3];
  logic [31:0] p_wdata[3];
  logic [31:0] e_rdata[3];
  logic        e_err [3];
  bit          e_known[3];
  logic [31:0] mem_m [3][64];
  bit          known [3][64];
  bit          rdy_e, bsy_e, rv_e;

  initial begin
    for (int i = 0; i < 3; i++) begin
      t_acc[i] = -1; t_rsp[i] = -1; t_free[i] = 0;
      e_rdata[i] = '0; e_err[i] = 1'b0; e_known[i] = 1'b1;
      v_addr[i] = '0; v_wdata[i] = '0;
      for (int w = 0; w < 64; w++) begin
        known[i][w] = 1'b0; mem_m[i][w] = '0;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      rdy_e = (cyc >= t_free[i]);
      rv_e  = (cyc == t_rsp[i]);
      bsy_e = ((cyc > t_acc[i]) && (cyc < t_rsp[i])) || (rdy_e && v_valid[i]);
      if (rv_e) begin
        e_err[i] = p_err[i];
        if (p_err[i] || p_we[i]) begin
          e_rdata[i] = '0; e_known[i] = 1'b1;
        end else begin
          e_rdata[i] = mem_m[i][p_idx[i]]; e_known[i] = known[i][p_idx[i]];
        end
      end
      if (model_ok) begin
        chk($sformatf("u%0d.req_ready", i), 32'(o_ready[i]), 32'(rdy_e));
        chk($sformatf("u%0d.busy", i), 32'(o_busy[i]), 32'(bsy_e));
        chk($sformatf("u%0d.rsp_valid", i), 32'(o_rvalid[i]), 32'(rv_e));
        chk($sformatf("u%0d.rsp_err", i), 32'(o_err[i]), 32'(e_err[i]));
        if (e_known[i]) chk($sformatf("u%0d.rsp_rdata", i), o_rdata[i], e_rdata[i]);
      end
      if (rv_e && p_we[i] && !p_err[i]) begin
        mem_m[i][p_idx[i]] = p_wdata[i];
        known[i][p_idx[i]] = 1'b1;
      end
      if (rst) begin
        t_free[i] = cyc + 1; t_rsp[i] = -1; t_acc[i] = -1;
        e_rdata[i] = '0; e_err[i] = 1'b0; e_known[i] = 1'b1;
      end else if (rdy_e && v_valid[i]) begin
        t_acc[i]  = cyc;
        t_rsp[i]  = cyc + lat(i);
        t_free[i] = cyc + lat(i) + 1;
        p_we[i]   = v_we[i];
        p_err[i]  = err_of(v_addr[i]);
        p_idx[i]  = idx_of(v_addr[i]);
        p_wdata[i] = v_wdata[i];
      end
    end
    if (rst) model_ok = 1'b1;
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int i, input logic v, input logic we, input logic [31:0] a,
                     input logic [31:0] d);
    v_valid[i] = v; v_we[i] = we; v_addr[i] = a; v_wdata[i] = d;
  endtask

  // Present one request for a single cycle from IDLE, then let it complete.
  task automatic one_req(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
    drv(i, 1'b1, we, a, d);
    tick();
    drv(i, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (lat(i)) tick();
  endtask

  logic [31:0] ra;

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // store then load held through WAIT/RESP on the LATENCY=2 instance
    drv(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    tick();
    drv(0, 1'b1, 1'b0, 32'h10, 32'h0);
    repeat (3) tick();
    drv(0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) tick();

    // reset while a store is waiting must leave the old word intact
    one_req(0, 1'b1, 32'h8, 32'hAAAA5555);
    drv(0, 1'b1, 1'b1, 32'h8, 32'h12345678);
    tick();
    drv(0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    one_req(0, 1'b0, 32'h8, 32'h0);

    // LATENCY=1 back-to-back loads with valid held
    one_req(1, 1'b1, 32'h0, 32'h0BAD0000);
    one_req(1, 1'b1, 32'h4, 32'h0BAD0004);
    drv(1, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    drv(1, 1'b1, 1'b0, 32'h4, 32'h0);
    repeat (2) tick();
    drv(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) tick();

    // LATENCY=3 with the second request held through WAIT
    drv(2, 1'b1, 1'b1, 32'h20, 32'hC0FFEE00);
    tick();
    drv(2, 1'b1, 1'b0, 32'h20, 32'h0);
    repeat (4) tick();
    drv(2, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) tick();

    // alignment / range / wrap cases
    one_req(0, 1'b1, 32'h0, 32'h01234567);
    one_req(0, 1'b0, 32'h102, 32'h0);
    one_req(0, 1'b1, 32'h100, 32'hFFFF0000);
    one_req(0, 1'b0, 32'h0, 32'h0);
    one_req(0, 1'b1, 32'h104, 32'h00000055);
    one_req(0, 1'b0, 32'h4, 32'h0);
    one_req(0, 1'b0, 32'h104, 32'h0);

    // randomized traffic on all three instances, with occasional resets
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        ra = 32'($urandom_range(0, 15)) * 4;
        if ($urandom_range(0, 7) == 0) ra = ra + 32'($urandom_range(1, 3)) * 256;
        if ($urandom_range(0, 5) == 0) ra = ra + 32'($urandom_range(1, 3));
        drv(i, ($urandom_range(0, 3) != 0), 1'($urandom), ra, $urandom);
      end
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) drv(i, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (6) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
